// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared display codes and state encoding for the game blocks
// Purpose: constants reused by every game block that drives the 7-segment value.
// Ports: none (package).
package game_pkg;

  // Display codes shown on the value output instead of a number
  localparam logic [3:0] CODE_OK    = 4'd10;
  localparam logic [3:0] CODE_WRONG = 4'd11;
  localparam logic [3:0] CODE_TIE   = 4'd12;
  localparam logic [3:0] CODE_OVER  = 4'd13;

  // Game FSM state encoding
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

endpackage

// File: rtl/game_higher_lower_scored_if.sv
// rtl/game_higher_lower_scored_if.sv - player/display bus of the higher/lower game
// Purpose: groups the random source, the buttons and the scored display outputs.
// Ports (signals): rnd, btn_higher, btn_lower, btn_restart (to game);
//   value, score, high_score, lives, game_over, result_valid (from game).
// Modports: master = stimulus/upstream side, slave = the game block.
interface game_higher_lower_scored_if #(
  parameter int WIDTH   = 4,
  parameter int SCORE_W = 8
);
  logic [WIDTH-1:0]   rnd;
  logic               btn_higher;
  logic               btn_lower;
  logic               btn_restart;
  logic [WIDTH-1:0]   value;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         lives;
  logic               game_over;
  logic               result_valid;

  modport master (
    output rnd, btn_higher, btn_lower, btn_restart,
    input  value, score, high_score, lives, game_over, result_valid
  );

  modport slave (
    input  rnd, btn_higher, btn_lower, btn_restart,
    output value, score, high_score, lives, game_over, result_valid
  );
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for one debounced button
// Purpose: one-cycle press pulse on each 0->1 transition; a held button never retriggers.
// Ports: clk, rst_n (async active-low), btn_i (level), press_o (pulse).
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;
endmodule

// File: rtl/game_higher_lower_scored.sv
// rtl/game_higher_lower_scored.sv - scored higher/lower guessing game FSM
// Purpose: shows a number, judges a higher/lower guess against the next random number,
//   flashes ok/wrong/tie for DELAY_TIME cycles, tracks score, high score and lives.
// Ports: clk, reset_n (async active-low), bus (slave modport: rnd and buttons in;
//   value, score, high_score, lives, game_over, result_valid out).
module game_higher_lower_scored
  import game_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_VALUE  = 9,
  parameter int DELAY_TIME = 10_000_000,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  game_higher_lower_scored_if.slave   bus
);
  localparam int CW = $clog2(DELAY_TIME + 1);

  localparam logic [WIDTH-1:0] MAXV       = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAXV_P1    = WIDTH'(MAX_VALUE + 1);
  localparam logic [WIDTH-1:0] V_OK       = WIDTH'(CODE_OK);
  localparam logic [WIDTH-1:0] V_WRONG    = WIDTH'(CODE_WRONG);
  localparam logic [WIDTH-1:0] V_TIE      = WIDTH'(CODE_TIE);
  localparam logic [WIDTH-1:0] V_OVER     = WIDTH'(CODE_OVER);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [CW-1:0]    CNT_LAST   = CW'(DELAY_TIME - 1);

  logic press_higher, press_lower, press_restart;

  btn_edge u_edge_higher  (.clk(clk), .rst_n(reset_n), .btn_i(bus.btn_higher),  .press_o(press_higher));
  btn_edge u_edge_lower   (.clk(clk), .rst_n(reset_n), .btn_i(bus.btn_lower),   .press_o(press_lower));
  btn_edge u_edge_restart (.clk(clk), .rst_n(reset_n), .btn_i(bus.btn_restart), .press_o(press_restart));

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [WIDTH-1:0]   nxt_q, nxt_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [2:0]         lives_q, lives_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rv_q, rv_d;
  logic [WIDTH-1:0]   r;

  // Fold the raw random number into the playable range 0..MAX_VALUE
  assign r = (bus.rnd > MAXV) ? bus.rnd - MAXV_P1 : bus.rnd;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    value_d = value_q;
    score_d = score_q;
    high_d  = high_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;

    // Restart beats any guess and drops a pending SHOW result
    if (press_restart) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          cur_d   = r;
          value_d = r;
          score_d = '0;
          lives_d = LIVES_INIT;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          // Both buttons in the same cycle is ambiguous and ignored
          if (press_higher ^ press_lower) begin
            nxt_d   = r;
            rv_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHOW;
            if (r == cur_q) begin
              value_d = V_TIE;
            end else if ((press_higher && (r > cur_q)) || (press_lower && (r < cur_q))) begin
              value_d = V_OK;
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
            end else begin
              value_d = V_WRONG;
              lives_d = lives_q - 3'd1;
            end
          end
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            if (lives_q == 3'd0) begin
              state_d = ST_OVER;
              value_d = V_OVER;
              if (score_q > high_q) high_d = score_q;
            end else begin
              // Continue from the number that was judged, not the live rnd
              cur_d   = nxt_q;
              value_d = nxt_q;
              state_d = ST_CHECK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          value_d = V_OVER;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cur_q   <= '0;
      nxt_q   <= '0;
      value_q <= '0;
      score_q <= '0;
      high_q  <= '0;
      lives_q <= LIVES_INIT;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      value_q <= value_d;
      score_q <= score_d;
      high_q  <= high_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.score        = score_q;
  assign bus.high_score   = high_q;
  assign bus.lives        = lives_q;
  assign bus.game_over    = (state_q == ST_OVER);
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_game_higher_lower_scored.sv
// tb/tb_game_higher_lower_scored.sv - self-checking bench for game_higher_lower_scored
// Purpose: directed play-through compared every cycle against a behavioural game model.
// Ports: none (top-level bench).
module tb_game_higher_lower_scored;
  localparam int WIDTH   = 4;
  localparam int MAXV    = 9;
  localparam int DELAY   = 4;
  localparam int LIVES   = 3;
  localparam int SCORE_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  game_higher_lower_scored_if #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) bus ();

  game_higher_lower_scored #(
    .WIDTH(WIDTH), .MAX_VALUE(MAXV), .DELAY_TIME(DELAY), .LIVES(LIVES), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int fold(input int x);
    return (x > MAXV) ? x - (MAXV + 1) : x;
  endfunction

  // Behavioural model: what a player should see, tracked with plain variables
  int exp_value = 0, exp_score = 0, exp_hi = 0, exp_lives = LIVES;
  bit exp_over = 0, exp_rv = 0;
  bit need_load = 1;
  int show_left = 0;
  int m_cur = 0, m_nxt = 0;
  bit prev_h = 0, prev_l = 0, prev_r = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_value = 0; exp_score = 0; exp_hi = 0; exp_lives = LIVES;
        exp_over = 0; exp_rv = 0; need_load = 1; show_left = 0;
        m_cur = 0; m_nxt = 0; prev_h = 0; prev_l = 0; prev_r = 0;
      end else begin
        bit ph, pl, pr;
        int rv;
        ph = bus.btn_higher & ~prev_h;
        pl = bus.btn_lower & ~prev_l;
        pr = bus.btn_restart & ~prev_r;
        rv = fold(int'(bus.rnd));
        exp_rv = 0;
        if (pr) begin
          need_load = 1; show_left = 0; exp_over = 0;
        end else if (need_load) begin
          m_cur = rv; exp_value = rv; exp_score = 0; exp_lives = LIVES; need_load = 0;
        end else if (exp_over) begin
          exp_value = 13;
        end else if (show_left > 0) begin
          show_left--;
          if (show_left == 0) begin
            if (exp_lives == 0) begin
              exp_over = 1; exp_value = 13;
              if (exp_score > exp_hi) exp_hi = exp_score;
            end else begin
              m_cur = m_nxt; exp_value = m_cur;
            end
          end
        end else if (ph != pl) begin
          m_nxt = rv; exp_rv = 1; show_left = DELAY;
          if (rv == m_cur) exp_value = 12;
          else if ((ph && rv > m_cur) || (pl && rv < m_cur)) begin
            exp_value = 10;
            if (exp_score < (1 << SCORE_W) - 1) exp_score++;
          end else begin
            exp_value = 11; exp_lives--;
          end
        end
        prev_h = bus.btn_higher; prev_l = bus.btn_lower; prev_r = bus.btn_restart;
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("value", int'(bus.value), exp_value);
      chk("score", int'(bus.score), exp_score);
      chk("high_score", int'(bus.high_score), exp_hi);
      chk("lives", int'(bus.lives), exp_lives);
      chk("game_over", int'(bus.game_over), int'(exp_over));
      chk("result_valid", int'(bus.result_valid), int'(exp_rv));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic guess(input bit h, input bit l, input int r);
    bus.rnd = WIDTH'(r);
    bus.btn_higher = h;
    bus.btn_lower = l;
    tick();
    bus.btn_higher = 1'b0;
    bus.btn_lower = 1'b0;
  endtask

  task automatic wait_show();
    repeat (DELAY) tick();
  endtask

  task automatic restart();
    bus.btn_restart = 1'b1;
    tick();
    bus.btn_restart = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    bus.rnd = 4'd5;
    bus.btn_higher = 1'b0;
    bus.btn_lower = 1'b0;
    bus.btn_restart = 1'b0;
    repeat (3) tick();
    chk("lit_reset_value", int'(bus.value), 0);
    chk("lit_reset_lives", int'(bus.lives), 3);
    reset_n = 1'b1;
    tick();
    chk("lit_init_value", int'(bus.value), 5);
    chk("lit_init_score", int'(bus.score), 0);
    chk("lit_init_over", int'(bus.game_over), 0);

    // correct higher guess, shown number comes from the latched nxt
    guess(1, 0, 8);
    chk("lit_ok_value", int'(bus.value), 10);
    chk("lit_ok_score", int'(bus.score), 1);
    chk("lit_ok_rv", int'(bus.result_valid), 1);
    bus.rnd = 4'd3;
    wait_show();
    chk("lit_after_show", int'(bus.value), 8);

    // tie with a held button: exactly one judgement
    bus.rnd = 4'd8;
    bus.btn_lower = 1'b1;
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus.result_valid) pulses++;
    end
    bus.btn_lower = 1'b0;
    chk("lit_held_pulses", pulses, 1);
    chk("lit_tie_score", int'(bus.score), 1);
    chk("lit_tie_lives", int'(bus.lives), 3);
    tick();

    guess(0, 1, 2); wait_show();
    chk("lit_cur2", int'(bus.value), 2);

    // three wrong guesses to game over
    guess(0, 1, 9); chk("lit_lives2", int'(bus.lives), 2); wait_show();
    guess(1, 0, 0); chk("lit_lives1", int'(bus.lives), 1); wait_show();
    guess(0, 1, 5); chk("lit_lives0", int'(bus.lives), 0); wait_show();
    chk("lit_over_value", int'(bus.value), 13);
    chk("lit_over_flag", int'(bus.game_over), 1);
    chk("lit_hi2", int'(bus.high_score), 2);
    guess(1, 0, 7); tick();
    chk("lit_over_ignore", int'(bus.value), 13);

    // restart, score 4, lose again: high score rises to 4
    bus.rnd = 4'd0;
    restart();
    chk("lit_rs_score", int'(bus.score), 0);
    chk("lit_rs_lives", int'(bus.lives), 3);
    chk("lit_rs_hi", int'(bus.high_score), 2);
    for (int i = 1; i <= 4; i++) begin
      guess(1, 0, i); wait_show();
    end
    chk("lit_score4", int'(bus.score), 4);
    guess(0, 1, 14); chk("lit_fold_tie", int'(bus.value), 12); wait_show();
    chk("lit_fold_cur", int'(bus.value), 4);
    guess(1, 0, 1); wait_show();
    guess(1, 0, 0); wait_show();
    guess(0, 1, 3); wait_show();
    chk("lit_hi4", int'(bus.high_score), 4);
    bus.rnd = 4'd14;
    restart();
    chk("lit_rs2_value", int'(bus.value), 4);
    chk("lit_rs2_hi", int'(bus.high_score), 4);

    // both buttons in one cycle: ignored
    bus.btn_higher = 1'b1; bus.btn_lower = 1'b1; tick();
    chk("lit_both_rv", int'(bus.result_valid), 0);
    bus.btn_higher = 1'b0; bus.btn_lower = 1'b0; tick();
    chk("lit_both_value", int'(bus.value), 4);

    // restart mid-SHOW
    guess(1, 0, 7); tick();
    bus.rnd = 4'd6;
    restart();
    chk("lit_midshow_value", int'(bus.value), 6);
    chk("lit_midshow_score", int'(bus.score), 0);
    wait_show();
    chk("lit_midshow_stay", int'(bus.value), 6);

    // async reset mid-SHOW
    guess(0, 1, 2); tick();
    reset_n = 1'b0;
    #1;
    chk("lit_rst_value", int'(bus.value), 0);
    chk("lit_rst_hi", int'(bus.high_score), 0);
    chk("lit_rst_lives", int'(bus.lives), 3);
    chk("lit_rst_score", int'(bus.score), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
